// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage CPU pipeline registers:
// control-field layout and per-boundary payload widths.
package pipe_pkg;

  localparam int PIPE_CTRL_W  = 8;

  // Control bits that must never reach state-writing stages on a squashed beat
  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_LSB = 1;
  localparam int MEMTOREG_W   = 2;
  localparam int MEMWRITE_BIT = 3;
  localparam int MEMREAD_BIT  = 4;
  localparam int BRANCH_BIT   = 5;
  localparam int ALUSRC_BIT   = 6;
  localparam int REGDST_BIT   = 7;

  typedef logic [PIPE_CTRL_W-1:0] ctrl_t;

  localparam int IFID_W  = 64;   // PC_4 + Instr
  localparam int IDEX_W  = 138;  // PC_4 + RD1 + RD2 + Imm + rt + rd
  localparam int EXMEM_W = 101;  // ALUOut + WriteData + PC_4 + dest
  localparam int MEMWB_W = 101;  // ALUOut + Read_Data + PC_4 + dest

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: payload, control and valid with load/clear enables.
// Load wins over clear so a same-edge retire+refill keeps the slot full.
module pipe_slot #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] next_data,
  input  logic [CTRL_W-1:0] next_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear drops valid and control only; the payload is left in place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      ctrl  <= next_ctrl;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush,
// optional 2-entry skid buffer (registered in_ready) and a flush-drop counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              accept;
  logic              retire;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_next_data;
  logic [CTRL_W-1:0] main_next_ctrl;
  logic [CNT_W:0]    drop_sum;

  assign out_valid = main_valid & ~stall;
  assign retire    = out_valid & out_ready & ~flush;
  assign accept    = in_valid & in_ready & ~flush;

  // The head refills from skid first so beat order is preserved
  always_comb begin
    main_load      = (retire & skid_valid) | (accept & (~main_valid | retire));
    main_clear     = flush | retire;
    main_next_data = in_data;
    main_next_ctrl = in_ctrl;
    if (skid_valid) begin
      main_next_data = skid_data;
      main_next_ctrl = skid_ctrl;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .next_data (main_next_data),
    .next_ctrl (main_next_ctrl),
    .valid     (main_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clear;
      logic skid_next_valid;
      logic ready_q;

      assign skid_load       = accept & main_valid & ~retire;
      assign skid_clear      = flush | (retire & skid_valid);
      assign skid_next_valid = skid_load | (skid_valid & ~skid_clear);

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .next_data (in_data),
        .next_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );

      // Ready depends only on our own next state, never on out_ready
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_q <= 1'b0;
        else      ready_q <= ~skid_next_valid;
      end

      assign in_ready = ready_q & ~stall;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = rst & ~stall & ~flush & (~main_valid | out_ready);
    end
  endgenerate

  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(occupancy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (flush)
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: single-entry, skid and narrow-counter
// instances share one stimulus bus; each scenario checks the instance it targets.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  ctrl_t       in_ctrl;
  logic        out_ready;
  logic        stall;
  logic        flush;

  logic        s0_in_ready, s0_out_valid;
  logic [15:0] s0_out_data;
  logic [7:0]  s0_out_ctrl;
  logic [1:0]  s0_occupancy;
  logic [15:0] s0_drop_cnt;

  logic        s1_in_ready, s1_out_valid;
  logic [15:0] s1_out_data;
  logic [7:0]  s1_out_ctrl;
  logic [1:0]  s1_occupancy;
  logic [15:0] s1_drop_cnt;

  logic        sat_in_ready, sat_out_valid;
  logic [15:0] sat_out_data;
  logic [7:0]  sat_out_ctrl;
  logic [1:0]  sat_occupancy;
  logic [1:0]  sat_drop_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s0_out_valid),
    .out_ready(out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
    .stall(stall), .flush(flush), .occupancy(s0_occupancy), .drop_cnt(s0_drop_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s1_out_valid),
    .out_ready(out_ready), .out_data(s1_out_data), .out_ctrl(s1_out_ctrl),
    .stall(stall), .flush(flush), .occupancy(s1_occupancy), .drop_cnt(s1_drop_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
    .stall(stall), .flush(flush), .occupancy(sat_occupancy), .drop_cnt(sat_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 8'hFF;
    out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0h expected 0", s1_out_valid); end
    checks++; if (s1_out_ctrl !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_ctrl: got %0h expected 0", s1_out_ctrl); end
    checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s1_in_ready: got %0h expected 0", s1_in_ready); end
    checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s0_in_ready: got %0h expected 0", s0_in_ready); end
    checks++; if (s1_drop_cnt !== 16'h0) begin failures++; $display("[TB] FAIL reset_drop_cnt: got %0h expected 0", s1_drop_cnt); end
    checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("[TB] FAIL reset_occupancy: got %0h expected 0", s1_occupancy); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL release_before_edge_in_ready: got %0h expected 0", s1_in_ready); end
    checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_s0_in_ready: got %0h expected 1", s0_in_ready); end
    tick();
    checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_first_edge_in_ready: got %0h expected 1", s1_in_ready); end
    // Asynchronous reset in the middle of a cycle with one beat held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077; in_ctrl = 8'h81;
    tick();
    in_valid = 1'b0;
    checks++; if (s1_occupancy !== 2'd1) begin failures++; $display("[TB] FAIL midreset_pre_occupancy: got %0h expected 1", s1_occupancy); end
    #2; rst = 1'b0; #1;
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid: got %0h expected 0", s1_out_valid); end
    checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("[TB] FAIL midreset_occupancy: got %0h expected 0", s1_occupancy); end
    checks++; if (s1_drop_cnt !== 16'h0) begin failures++; $display("[TB] FAIL midreset_drop_cnt: got %0h expected 0", s1_drop_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_streaming;
    do_reset();
    out_ready = 1'b1; in_ctrl = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      #1;
      checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_s1_in_ready beat %0d: got %0h expected 1", i, s1_in_ready); end
      tick();
      checks++; if (s0_out_data !== 16'(i) || s0_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_s0 beat %0d: got data %0h valid %0h expected data %0h valid 1", i, s0_out_data, s0_out_valid, i); end
      checks++; if (s1_out_data !== 16'(i) || s1_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_s1 beat %0d: got data %0h valid %0h expected data %0h valid 1", i, s1_out_data, s1_out_valid, i); end
      checks++; if (s1_out_ctrl !== 8'hA5 || s0_out_ctrl !== 8'hA5) begin failures++; $display("[TB] FAIL stream_ctrl beat %0d: got %0h/%0h expected a5", i, s0_out_ctrl, s1_out_ctrl); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (s0_out_valid !== 1'b0 || s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain_valid: got %0h/%0h expected 0/0", s0_out_valid, s1_out_valid); end
    checks++; if (s0_out_ctrl !== 8'h00 || s1_out_ctrl !== 8'h00) begin failures++; $display("[TB] FAIL stream_drain_ctrl: got %0h/%0h expected 0/0", s0_out_ctrl, s1_out_ctrl); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0; in_ctrl = 8'h01;
    in_valid = 1'b1; in_data = 16'h0011; tick();
    in_data = 16'h0022; tick();
    checks++; if (s1_occupancy !== 2'd2) begin failures++; $display("[TB] FAIL bp_occupancy_full: got %0h expected 2", s1_occupancy); end
    checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_full: got %0h expected 0", s1_in_ready); end
    checks++; if (s1_out_data !== 16'h0011) begin failures++; $display("[TB] FAIL bp_head_data: got %0h expected 11", s1_out_data); end
    in_data = 16'h0099; tick();
    checks++; if (s1_occupancy !== 2'd2) begin failures++; $display("[TB] FAIL bp_hold_occupancy: got %0h expected 2", s1_occupancy); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (s1_out_data !== 16'h0022 || s1_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_beat: got data %0h valid %0h expected 22 valid 1", s1_out_data, s1_out_valid); end
    checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_in_ready_back: got %0h expected 1", s1_in_ready); end
    checks++; if (s1_occupancy !== 2'd1) begin failures++; $display("[TB] FAIL bp_occupancy_one: got %0h expected 1", s1_occupancy); end
    tick();
    checks++; if (s1_out_valid !== 1'b0 || s1_occupancy !== 2'd0) begin failures++; $display("[TB] FAIL bp_empty: got valid %0h occ %0h expected 0/0", s1_out_valid, s1_occupancy); end
  endtask

  task automatic test_flush_full;
    do_reset();
    out_ready = 1'b0; in_ctrl = 8'h0F;
    in_valid = 1'b1; in_data = 16'h0011; tick();
    in_data = 16'h0022; tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0033; out_ready = 1'b1;
    #1;
    checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_s0_in_ready: got %0h expected 0", s0_in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("[TB] FAIL flush_occupancy: got %0h expected 0", s1_occupancy); end
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid: got %0h expected 0", s1_out_valid); end
    checks++; if (s1_out_ctrl !== 8'h00) begin failures++; $display("[TB] FAIL flush_out_ctrl: got %0h expected 0", s1_out_ctrl); end
    checks++; if (s1_drop_cnt !== 16'd2) begin failures++; $display("[TB] FAIL flush_drop_cnt_s1: got %0h expected 2", s1_drop_cnt); end
    checks++; if (s0_drop_cnt !== 16'd1) begin failures++; $display("[TB] FAIL flush_drop_cnt_s0: got %0h expected 1", s0_drop_cnt); end
    checks++; if (s1_out_data !== 16'h0011) begin failures++; $display("[TB] FAIL flush_payload_kept: got %0h expected 11", s1_out_data); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_ghost cycle %0d: got valid %0h data %0h expected valid 0", c, s1_out_valid, s1_out_data); end
    end
  endtask

  task automatic test_stall_flush;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0044; in_ctrl = 8'h3C;
    tick();
    in_data = 16'h0055; stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (s1_in_ready !== 1'b0 || s0_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready: got %0h/%0h expected 0/0", s0_in_ready, s1_in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00) begin failures++; $display("[TB] FAIL stall_masked cycle %0d: got valid %0h ctrl %0h expected 0/0", c, s1_out_valid, s1_out_ctrl); end
      checks++; if (s1_occupancy !== 2'd1 || s1_out_data !== 16'h0044) begin failures++; $display("[TB] FAIL stall_hold cycle %0d: got occ %0h data %0h expected 1/44", c, s1_occupancy, s1_out_data); end
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    checks++; if (s1_occupancy !== 2'd0) begin failures++; $display("[TB] FAIL stallflush_occupancy: got %0h expected 0", s1_occupancy); end
    checks++; if (s1_drop_cnt !== 16'd1) begin failures++; $display("[TB] FAIL stallflush_drop_cnt: got %0h expected 1", s1_drop_cnt); end
    #1;
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stallflush_out_valid: got %0h expected 0", s1_out_valid); end
    tick();
  endtask

  task automatic test_saturation;
    int model;
    do_reset();
    model = 0;
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'(16'hA0 + r); in_ctrl = 8'h11;
      tick(); tick();
      checks++; if (sat_occupancy !== 2'd2) begin failures++; $display("[TB] FAIL sat_fill round %0d: got %0h expected 2", r, sat_occupancy); end
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      model = (model + 2 > 3) ? 3 : model + 2;
      checks++; if (sat_drop_cnt !== 2'(model)) begin failures++; $display("[TB] FAIL sat_drop_cnt round %0d: got %0h expected %0h", r, sat_drop_cnt, model); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q[$];
    logic [15:0] exp;
    int sent;
    int got;
    do_reset();
    sent = 0; got = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (sent < 6); in_data = 16'(sent + 1); in_ctrl = 8'h5A;
      out_ready = (c % 3) != 0;
      #1;
      if (s1_out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_spurious cycle %0d: got data %0h expected no beat", c, s1_out_data);
        end else begin
          exp = q.pop_front();
          if (s1_out_data !== exp || s1_out_ctrl !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_order cycle %0d: got data %0h ctrl %0h expected data %0h ctrl 5a", c, s1_out_data, s1_out_ctrl, exp); end
          got++;
        end
      end
      if (in_valid && s1_in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (got !== 6) begin failures++; $display("[TB] FAIL b2b_count: got %0d beats expected 6", got); end
  endtask

  initial begin
    $display("[TB] starting pipe_stage_reg bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_stall_flush();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage CPU, intended for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
- Carries a data payload and a control field, with a valid/ready handshake, stall and flush.
- Has an optional 2-entry skid mode that registers the upstream ready, plus a saturating counter of beats discarded by flush.
- Control bits are zeroed on flush, so a squashed instruction never writes registers or memory.

Parameters:
- DATA_W, 96: payload width (e.g. ALUOut + PC_4 + Read_Data).
- CTRL_W, 8: control field width; zeroed on flush/reset (RegWrite, MemtoReg, ...).
- SKID, 0: 0 = single entry, combinational in_ready; 1 = two entries, registered in_ready.
- CNT_W, 16: width of the flush-drop counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  head beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0
- stall  in  1  freeze: no accept, no release
- flush  in  1  squash all held beats
- occupancy  out  2  entries held (0..1 if SKID=0, 0..2 if SKID=1)
- drop_cnt  out  CNT_W  saturating count of valid beats discarded by flush

Behaviour:
- Reset (rst=0, asynchronous): all entry valids, out_data, out_ctrl, occupancy and drop_cnt are 0. in_ready=0 while rst=0.
- Handshakes:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Release occurs when out_valid & out_ready at a rising edge.
  - Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- stall=1:
  - in_ready=0 and out_valid is masked to 0, so no transfer occurs.
  - Held contents, occupancy and drop_cnt are unchanged.
- SKID=0:
  - in_ready = rst & !stall & !flush & (!valid | out_ready).
  - Accept and release in the same edge gives back-to-back throughput of 1 beat/cycle.
- SKID=1:
  - Entries are main (head) and skid; in_ready is a register.
  - in_ready is 1 when skid is empty and the next-state stall=0. On the first edge after reset release it becomes 1.
  - When main is full, out_ready=0 and a beat is accepted, the beat goes to skid and in_ready drops the next cycle.
  - On release, skid moves to main. If a new beat is accepted on the same edge, it fills the vacated slot, preserving order.
  - Full throughput is 1 beat/cycle with no combinational in→out ready path.
- flush=1 (priority over stall, accept and release):
  - At the next edge all entry valids and ctrl fields clear to 0 and occupancy goes to 0.
  - An in_valid beat presented on that edge is not accepted (in_ready=0 combinationally in SKID=0; ignored in SKID=1).
  - Payload data registers are not cleared.
  - drop_cnt += number of valid entries held, saturating at 2^CNT_W−1.
- out_ctrl is forced to 0 whenever out_valid=0, so downstream may sample it unconditionally.
- Beat order is strictly FIFO; no beat is ever duplicated or lost except by flush.
- Reset asserted mid-operation discards all entries immediately; drop_cnt is not incremented by reset.
- Simultaneous flush and stall: flush wins.
- Simultaneous accept and release when occupancy=2 (SKID=1): impossible, because in_ready=0 in that state.

Decomposition:
- Package pipe_pkg holds:
  - control-field widths and bit positions (REGWRITE_BIT, MEMTOREG_LSB/W=2, MEMWRITE_BIT, ...);
  - typedef ctrl_t;
  - per-boundary DATA_W constants (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
- One sub-module, pipe_slot: one data+ctrl+valid register with load/clear enables, instantiated once or twice depending on SKID.

Test Plan:
- Reset, SKID=1: drive rst=0 with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=0, drop_cnt=0. Release rst → in_ready=1 after the first edge.
- Streaming, SKID=0 and 1: out_ready=1, beats data=0x1..0x8, ctrl=0xA5 → each out_data appears 1 cycle later, 8 beats in 8 cycles, in order.
- Backpressure, SKID=1: out_ready=0, send 0x11 then 0x22 → occupancy=2, in_ready=0; out_ready=1 → 0x11 then 0x22 released, in_ready returns to 1.
- Flush while full, SKID=1: occupancy=2, flush=1 with in_valid=1 data=0x33 → next cycle occupancy=0, out_valid=0, out_ctrl=0, drop_cnt=2, and 0x33 is never output.
- Stall plus flush: stall=1 for 3 cycles with occupancy=1 → contents held, out_valid=0. Then stall=1 & flush=1 → flush wins: occupancy=0, drop_cnt+1.
- Saturation, CNT_W=2: flush a full stage 3 times → drop_cnt=3 (saturated), not wrapped.
